// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick_timer block: FSM state encoding and default width.
package tick_timer_pkg;

  localparam int unsigned TT_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tt_state_e;

endpackage

// File: rtl/reload_downcounter.sv
// Loadable down-counter that decrements on request and saturates at zero.
// Priority: clear > load > decrement. Provides zero and one detects.
module reload_downcounter
  import tick_timer_pkg::*;
#(
  parameter int unsigned WIDTH = TT_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_is_zero,
  output logic             o_is_one
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_count   = r_count;
  assign o_is_zero = (r_count == '0);
  assign o_is_one  = (r_count == ONE);

endmodule

// File: rtl/tick_timer.sv
// Programmable interval timer counting prescaler ticks, with one-shot/periodic
// modes, sticky irq/overrun flags and a prescaler hold output.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned WIDTH = TT_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] period,
  input  logic             irq_ack,
  output logic             prescaler_hold,
  output logic             busy,
  output logic [WIDTH-1:0] remaining,
  output logic             irq,
  output logic             overrun
);

  tt_state_e        r_state;
  tt_state_e        w_state_nxt;
  logic [WIDTH-1:0] r_period;
  logic             r_periodic;
  logic             r_busy;
  logic             r_hold;
  logic             r_irq;
  logic             r_overrun;

  logic             w_start_ok;
  logic             w_cnt_clear;
  logic             w_cnt_load;
  logic [WIDTH-1:0] w_cnt_load_val;
  logic             w_cnt_dec;
  logic             w_latch;
  logic             w_expire;
  logic [WIDTH-1:0] w_count;
  logic             w_cnt_zero;
  logic             w_cnt_one;

  assign w_start_ok = start && (period != '0);

  reload_downcounter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk        (clk),
    .rst        (reset),
    .i_clear    (w_cnt_clear),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_count    (w_count),
    .o_is_zero  (w_cnt_zero),
    .o_is_one   (w_cnt_one)
  );

  // Priority within each state: stop > start > tick.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_clear    = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = period;
    w_cnt_dec      = 1'b0;
    w_latch        = 1'b0;
    w_expire       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = ST_RUN;
          w_cnt_load  = 1'b1;
          w_latch     = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_cnt_clear = 1'b1;
        end else if (w_start_ok) begin
          w_cnt_load = 1'b1;
          w_latch    = 1'b1;
        end else if (tick && !w_cnt_zero) begin
          if (w_cnt_one) begin
            w_expire = 1'b1;
            if (r_periodic) begin
              w_cnt_load     = 1'b1;
              w_cnt_load_val = r_period;
            end else begin
              w_cnt_clear = 1'b1;
              w_state_nxt = ST_DONE;
            end
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_start_ok) begin
          w_state_nxt = ST_RUN;
          w_cnt_load  = 1'b1;
          w_latch     = 1'b1;
        end else if (irq_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_clear = 1'b1;
      end
    endcase
  end

  // busy/hold decode the next state so they change on the same edge as r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_hold  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_hold  <= (w_state_nxt != ST_RUN);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period   <= '0;
      r_periodic <= 1'b0;
    end else if (w_latch) begin
      r_period   <= period;
      r_periodic <= periodic;
    end
  end

  // Expiry outranks a simultaneous acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq     <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_expire) begin
      r_irq <= 1'b1;
      if (r_irq && !irq_ack) begin
        r_overrun <= 1'b1;
      end
    end else if (irq_ack) begin
      r_irq     <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign prescaler_hold = r_hold;
  assign busy           = r_busy;
  assign remaining      = w_count;
  assign irq            = r_irq;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer (WIDTH=8) with a per-cycle reference model.
module tb_tick_timer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick;
  logic         start;
  logic         stop;
  logic         periodic;
  logic [W-1:0] period;
  logic         irq_ack;
  logic         prescaler_hold;
  logic         busy;
  logic [W-1:0] remaining;
  logic         irq;
  logic         overrun;

  int errors = 0;
  int checks = 0;
  int irq_rises = 0;
  logic irq_q = 1'b0;

  always #5 clk = ~clk;

  tick_timer #(
    .WIDTH (W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .start          (start),
    .stop           (stop),
    .periodic       (periodic),
    .period         (period),
    .irq_ack        (irq_ack),
    .prescaler_hold (prescaler_hold),
    .busy           (busy),
    .remaining      (remaining),
    .irq            (irq),
    .overrun        (overrun)
  );

  // Reference model: only "timing active or not" matters externally.
  bit m_run  = 1'b0;
  bit m_mode = 1'b0;
  bit m_irq  = 1'b0;
  bit m_ovr  = 1'b0;
  int m_rem  = 0;
  int m_per  = 0;

  always @(posedge clk or posedge reset) begin : model
    bit sok;
    bit expired;
    if (reset) begin
      m_run = 0; m_mode = 0; m_irq = 0; m_ovr = 0; m_rem = 0; m_per = 0;
    end else begin
      sok     = start && (period != 0);
      expired = 0;
      if (m_run && stop) begin
        m_run = 0;
        m_rem = 0;
      end else if (sok) begin
        m_run  = 1;
        m_rem  = int'(period);
        m_per  = int'(period);
        m_mode = periodic;
      end else if (m_run && tick) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          expired = 1;
          if (m_mode) m_rem = m_per;
          else        m_run = 0;
        end
      end
      if (expired) begin
        if (m_irq && !irq_ack) m_ovr = 1;
        m_irq = 1;
      end else if (irq_ack) begin
        m_irq = 0;
        m_ovr = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_busy", busy, m_run);
    chk("model_hold", prescaler_hold, !m_run);
    chk("model_remaining", remaining, m_rem);
    chk("model_irq", irq, m_irq);
    chk("model_overrun", overrun, m_ovr);
    if (irq && !irq_q) irq_rises++;
    irq_q = irq;
  end

  task automatic step(input logic t, input logic s, input logic sp, input logic pm,
                      input logic [W-1:0] p, input logic ack);
    tick = t; start = s; stop = sp; periodic = pm; period = p; irq_ack = ack;
    @(negedge clk);
    tick = 0; start = 0; stop = 0; periodic = 0; period = '0; irq_ack = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Prescaler stand-in: one tick every fourth clock.
  task automatic do_tick();
    idle(3);
    step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int rises0;
    tick = 0; start = 0; stop = 0; periodic = 0; period = '0; irq_ack = 0;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 0;
    chk("rst_remaining", remaining, 0);
    chk("rst_hold", prescaler_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);

    // 1. one-shot period 3
    step(0, 1, 0, 0, 3, 0);
    chk("os_busy", busy, 1);
    chk("os_hold", prescaler_hold, 0);
    chk("os_rem3", remaining, 3);
    do_tick(); chk("os_rem2", remaining, 2);
    do_tick(); chk("os_rem1", remaining, 1); chk("os_irq_early", irq, 0);
    do_tick();
    chk("os_rem0", remaining, 0);
    chk("os_irq", irq, 1);
    chk("os_done_busy", busy, 0);
    chk("os_done_hold", prescaler_hold, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("os_ack_irq", irq, 0);

    // 2. periodic period 2, ack after each irq
    rises0 = irq_rises;
    step(0, 1, 0, 1, 2, 0);
    chk("per_rem_load", remaining, 2);
    for (int k = 0; k < 3; k++) begin
      do_tick(); chk("per_rem1", remaining, 1);
      do_tick(); chk("per_rem2", remaining, 2); chk("per_irq", irq, 1);
      step(0, 0, 0, 0, 0, 1); chk("per_ack", irq, 0);
    end
    chk("per_irq_count", irq_rises - rises0, 3);
    chk("per_overrun", overrun, 0);
    chk("per_busy", busy, 1);
    step(0, 0, 1, 0, 0, 0);
    chk("per_stop_busy", busy, 0);

    // 3. overrun
    step(0, 1, 0, 1, 1, 0);
    do_tick(); chk("ovr_irq1", irq, 1); chk("ovr_ov0", overrun, 0);
    do_tick(); chk("ovr_ov1", overrun, 1); chk("ovr_irq2", irq, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("ovr_ack_irq", irq, 0); chk("ovr_ack_ov", overrun, 0);
    step(0, 0, 1, 0, 0, 0);

    // 4a. stop & tick at remaining 1
    step(0, 1, 0, 0, 2, 0);
    do_tick(); chk("col_rem1", remaining, 1);
    idle(3);
    step(1, 0, 1, 0, 0, 0);
    chk("col_stop_busy", busy, 0); chk("col_stop_irq", irq, 0);
    chk("col_stop_rem", remaining, 0);
    // 4b. restart & tick in RUN
    step(0, 1, 0, 0, 7, 0);
    do_tick(); chk("col_rem6", remaining, 6);
    idle(3);
    step(1, 1, 0, 0, 5, 0);
    chk("col_restart_rem", remaining, 5); chk("col_restart_busy", busy, 1);
    step(0, 0, 1, 0, 0, 0);
    // 4c. expiry & ack together
    step(0, 1, 0, 1, 1, 0);
    do_tick(); chk("col_irq", irq, 1);
    idle(3);
    step(1, 0, 0, 0, 0, 1);
    chk("col_expack_irq", irq, 1); chk("col_expack_ov", overrun, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);

    // 5. illegal period and ticks in IDLE
    step(0, 1, 0, 1, 0, 0);
    chk("ill_busy", busy, 0); chk("ill_hold", prescaler_hold, 1);
    chk("ill_rem", remaining, 0);
    do_tick(); do_tick();
    chk("idle_rem", remaining, 0); chk("idle_irq", irq, 0); chk("idle_busy", busy, 0);

    // 6. async reset mid-RUN with an irq pending
    step(0, 1, 0, 1, 1, 0);
    do_tick(); chk("rr_irq_pend", irq, 1);
    step(0, 1, 0, 0, 5, 0);
    do_tick(); do_tick();
    chk("rr_rem3", remaining, 3);
    #2 reset = 1;
    #1;
    chk("rr_rem", remaining, 0); chk("rr_irq", irq, 0);
    chk("rr_busy", busy, 0); chk("rr_hold", prescaler_hold, 1);
    chk("rr_ov", overrun, 0);
    #1 reset = 0;
    step(0, 1, 0, 0, 2, 0);
    chk("rr_restart_busy", busy, 1); chk("rr_restart_rem", remaining, 2);
    do_tick(); chk("rr_restart_rem1", remaining, 1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
